// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared types and defaults for the game-flow sequencer.
//   stage_t             - top-level game-flow state encoding
//   DEFAULT_CLK_FREQ_HZ - default clock rate, one oneSecPulse per this many clks
// Optional feature macro used by the files importing this package: PAUSE_EN.
package game_flow_pkg;

    typedef enum logic [2:0] {
        TITLE       = 3'd0,
        PLAY        = 3'd1,
        RESULT_OK   = 3'd2,
        RESULT_FAIL = 3'd3,
        GAME_WON    = 3'd4
    } stage_t;

    localparam int DEFAULT_CLK_FREQ_HZ = 25_000_000;

endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: bundle between the sequencer, its key inputs and the level stage.
// Parameter MAX_LEVEL sizes levelIndex ($clog2(MAX_LEVEL+1) bits).
// Signals:
//   startKey, pauseKey      in  debounced keys, level-sensitive (rising edge used)
//   stageEnded              in  1-clk pulse from level stage
//   stageFailed             in  verdict, qualified by stageEnded
//   lastLevelEnded          in  final level done, qualified by stageEnded
//   levelEnable             out high only in PLAY; rising edge reloads the level
//   cycleLevel              out 1-clk pulse on entering PLAY
//   oneSecPulse             out 1-clk pulse every CLK_FREQ_HZ clks
//   titleEnable/resultEnable/resultWin  screen selects
//   levelIndex              out current level
//   paused                  out pause flag
// Handshake: no valid/ready pairs here; stageEnded is a single-cycle strobe that
// qualifies stageFailed/lastLevelEnded, and every output is a registered level
// except cycleLevel/oneSecPulse, which are registered single-cycle strobes.
// Macro PAUSE_EN adds pauseKey and paused.
interface stage_sequencer_if #(
    parameter int MAX_LEVEL = 1
);
    localparam int LW = $clog2(MAX_LEVEL + 1);

    logic          startKey;
    logic          stageEnded;
    logic          stageFailed;
    logic          lastLevelEnded;
    logic          levelEnable;
    logic          cycleLevel;
    logic          oneSecPulse;
    logic          titleEnable;
    logic          resultEnable;
    logic          resultWin;
    logic [LW-1:0] levelIndex;

`ifdef PAUSE_EN
    logic          pauseKey;
    logic          paused;

    modport master (
        input  startKey, stageEnded, stageFailed, lastLevelEnded, pauseKey,
        output levelEnable, cycleLevel, oneSecPulse, titleEnable,
               resultEnable, resultWin, levelIndex, paused
    );
    modport slave (
        output startKey, stageEnded, stageFailed, lastLevelEnded, pauseKey,
        input  levelEnable, cycleLevel, oneSecPulse, titleEnable,
               resultEnable, resultWin, levelIndex, paused
    );
`else
    modport master (
        input  startKey, stageEnded, stageFailed, lastLevelEnded,
        output levelEnable, cycleLevel, oneSecPulse, titleEnable,
               resultEnable, resultWin, levelIndex
    );
    modport slave (
        output startKey, stageEnded, stageFailed, lastLevelEnded,
        input  levelEnable, cycleLevel, oneSecPulse, titleEnable,
               resultEnable, resultWin, levelIndex
    );
`endif

endinterface

// File: rtl/stage_sequencer_ticker.sv
// one_sec_ticker: free-running 0..CLK_FREQ_HZ-1 counter with a registered pulse.
// Ports:
//   clk, resetN  clock, async active-low reset
//   clear        restart the count at 0 (state entry); suppresses the pulse
//   hold         freeze the count and suppress the pulse
//   pulse        registered, high for the cycle the count has wrapped to 0
//   wrap         combinational: the count wraps on the coming edge (ignores clear,
//                so a consumer may use it to decide on a clear without a loop)
module one_sec_ticker
    import game_flow_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic hold,
    output logic pulse,
    output logic wrap
);
    localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] count_q, count_d;
    logic          pulse_q;

    always_comb begin
        wrap    = !hold && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!hold) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= wrap && !clear;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: game-flow FSM upstream of the level stage.
// TITLE -> PLAY -> RESULT_OK / RESULT_FAIL / GAME_WON -> next level or TITLE.
// Ports:
//   clk, resetN   clock, async active-low reset
//   bus           stage_sequencer_if.master (keys, level-stage status, screen outputs)
//   state_dbg_o   current FSM state
// Parameters: CLK_FREQ_HZ, MAX_LEVEL, RESULT_HOLD_S (>= 1).
// Macro PAUSE_EN: pauseKey toggles a pause in PLAY that freezes the second counter.
// All outputs are registered from the next state, so they change on the same
// edge the state register does.
module stage_sequencer
    import game_flow_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = DEFAULT_CLK_FREQ_HZ,
    parameter int MAX_LEVEL     = 1,
    parameter int RESULT_HOLD_S = 3
) (
    input  logic             clk,
    input  logic             resetN,
    stage_sequencer_if.master bus,
    output stage_t           state_dbg_o
);
    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int HW = $clog2(RESULT_HOLD_S + 1);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(MAX_LEVEL - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESULT_HOLD_S - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(RESULT_HOLD_S);

    stage_t        state_q, state_d;
    logic          start_prev_q;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic          level_en_q, level_en_d;
    logic          cycle_q, cycle_d;
    logic          title_q, title_d;
    logic          result_q, result_d;
    logic          win_q, win_d;

    logic start_rise, entering, timeout, in_hold_state;
    logic tick_wrap, tick_pulse, tick_hold;

    // Previous key value resets high so a key held through reset never starts a game.
    assign start_rise = bus.startKey && !start_prev_q;
    assign in_hold_state = (state_q == RESULT_OK) || (state_q == RESULT_FAIL);
    // Timeout fires on the wrap that would bring holdCnt to RESULT_HOLD_S.
    assign timeout = tick_wrap && (hold_cnt_q == HOLD_LAST);
    assign entering = (state_d != state_q);

`ifdef PAUSE_EN
    logic pause_prev_q, paused_q, paused_d;
    logic pause_rise;

    assign pause_rise = bus.pauseKey && !pause_prev_q;
    assign tick_hold  = paused_q;

    always_comb begin
        paused_d = paused_q;
        if (state_d != PLAY) begin
            paused_d = 1'b0;
        end else if (state_q == PLAY && pause_rise) begin
            paused_d = !paused_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pause_prev_q <= 1'b1;
            paused_q     <= 1'b0;
        end else begin
            pause_prev_q <= bus.pauseKey;
            paused_q     <= paused_d;
        end
    end

    assign bus.paused = paused_q;
`else
    assign tick_hold = 1'b0;
`endif

    one_sec_ticker #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_ticker (
        .clk    (clk),
        .resetN (resetN),
        .clear  (entering),
        .hold   (tick_hold),
        .pulse  (tick_pulse),
        .wrap   (tick_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= TITLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in PLAY startKey is simply not looked at, so stageEnded wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TITLE: begin
                if (start_rise) state_d = PLAY;
            end
            PLAY: begin
                if (bus.stageEnded) begin
                    if (bus.stageFailed) begin
                        state_d = RESULT_FAIL;
                    end else if (bus.lastLevelEnded || level_q == LAST_LEVEL) begin
                        state_d = GAME_WON;
                    end else begin
                        state_d = RESULT_OK;
                    end
                end
            end
            RESULT_OK: begin
                if (timeout || start_rise) state_d = PLAY;
            end
            RESULT_FAIL: begin
                if (timeout || start_rise) state_d = TITLE;
            end
            GAME_WON: begin
                if (start_rise) state_d = TITLE;
            end
            default: state_d = TITLE;
        endcase
    end

    // Output logic, computed from the next state and registered below.
    always_comb begin
        level_en_d = (state_d == PLAY);
        cycle_d    = entering && (state_d == PLAY);
        title_d    = (state_d == TITLE);
        result_d   = (state_d == RESULT_OK) || (state_d == RESULT_FAIL) ||
                     (state_d == GAME_WON);
        win_d      = (state_d == RESULT_OK) || (state_d == GAME_WON);
    end

    // Datapath: hold counter and level index.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (entering) begin
            hold_cnt_d = '0;
        end else if (in_hold_state && tick_wrap && hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end

        level_d = level_q;
        if (entering && state_d == TITLE) begin
            level_d = '0;
        end else if (entering && state_d == PLAY) begin
            if (state_q == RESULT_OK) begin
                level_d = (level_q == LAST_LEVEL) ? level_q : level_q + LW'(1);
            end else begin
                level_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_prev_q <= 1'b1;
            hold_cnt_q   <= '0;
            level_q      <= '0;
            level_en_q   <= 1'b0;
            cycle_q      <= 1'b0;
            title_q      <= 1'b1;
            result_q     <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            start_prev_q <= bus.startKey;
            hold_cnt_q   <= hold_cnt_d;
            level_q      <= level_d;
            level_en_q   <= level_en_d;
            cycle_q      <= cycle_d;
            title_q      <= title_d;
            result_q     <= result_d;
            win_q        <= win_d;
        end
    end

    assign bus.levelEnable  = level_en_q;
    assign bus.cycleLevel   = cycle_q;
    assign bus.oneSecPulse  = tick_pulse;
    assign bus.titleEnable  = title_q;
    assign bus.resultEnable = result_q;
    assign bus.resultWin    = win_q;
    assign bus.levelIndex   = level_q;
    assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer with
// CLK_FREQ_HZ=10, MAX_LEVEL=2, RESULT_HOLD_S=2. Pause scenario only with PAUSE_EN.
module tb_stage_sequencer;
    import game_flow_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int ML     = 2;
    localparam int HOLD   = 2;

    logic   clk = 1'b0;
    logic   resetN = 1'b0;
    stage_t state_dbg;
    int     checks = 0;
    int     failures = 0;

    stage_sequencer_if #(.MAX_LEVEL(ML)) bus ();

    stage_sequencer #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .MAX_LEVEL     (ML),
        .RESULT_HOLD_S (HOLD)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // {titleEnable, levelEnable, resultEnable, resultWin}
    function automatic logic [3:0] flags();
        return {bus.titleEnable, bus.levelEnable, bus.resultEnable, bus.resultWin};
    endfunction

    // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.startKey = 1'b0;
        step(1);
        bus.startKey = 1'b1;
        step(1);
        bus.startKey = 1'b0;
    endtask

    task automatic pulse_stage_end(input logic failed, input logic last);
        bus.stageEnded     = 1'b1;
        bus.stageFailed    = failed;
        bus.lastLevelEnded = last;
        step(1);
        bus.stageEnded     = 1'b0;
        bus.stageFailed    = 1'b0;
        bus.lastLevelEnded = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.startKey = 1'b1;
        step(2);
        checks++;
        if (flags() !== 4'b1000) begin
            failures++; $display("FAIL reset_flags got=%b exp=%b", flags(), 4'b1000);
        end
        checks++;
        if (bus.cycleLevel !== 1'b0 || bus.oneSecPulse !== 1'b0 || bus.levelIndex !== 2'd0) begin
            failures++; $display("FAIL reset_misc got=%b%b%0d exp=000", bus.cycleLevel, bus.oneSecPulse, bus.levelIndex);
        end
        resetN = 1'b1;
        step(3);
        checks++;
        if (state_dbg !== TITLE || flags() !== 4'b1000) begin
            failures++; $display("FAIL held_key_no_start got=%s/%b exp=TITLE/1000", state_dbg.name(), flags());
        end
    endtask

    task automatic test_start_and_pulses();
        press_start();
        checks++;
        if (flags() !== 4'b0100 || bus.cycleLevel !== 1'b1 || bus.levelIndex !== 2'd0) begin
            failures++; $display("FAIL start_play got=%b cyc=%b lvl=%0d exp=0100 cyc=1 lvl=0", flags(), bus.cycleLevel, bus.levelIndex);
        end
        for (int k = 1; k <= 35; k++) begin
            step(1);
            checks++;
            if (bus.oneSecPulse !== (k % 10 == 0)) begin
                failures++; $display("FAIL sec_pulse k=%0d got=%b exp=%b", k, bus.oneSecPulse, (k % 10 == 0));
            end
            if (k == 1) begin
                checks++;
                if (bus.cycleLevel !== 1'b0 || bus.levelEnable !== 1'b1) begin
                    failures++; $display("FAIL cycle_one_clk got cyc=%b en=%b exp cyc=0 en=1", bus.cycleLevel, bus.levelEnable);
                end
            end
        end
        pulse_stage_end(1'b0, 1'b0);
        checks++;
        if (state_dbg !== RESULT_OK || flags() !== 4'b0011) begin
            failures++; $display("FAIL to_result_ok got=%s/%b exp=RESULT_OK/0011", state_dbg.name(), flags());
        end
    endtask

    task automatic test_result_timeout();
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++;
            if (k < 20 && flags() !== 4'b0011) begin
                failures++; $display("FAIL result_hold k=%0d got=%b exp=0011", k, flags());
            end else if (k == 20 && (flags() !== 4'b0100 || bus.cycleLevel !== 1'b1 || bus.levelIndex !== 2'd1)) begin
                failures++; $display("FAIL result_advance got=%b cyc=%b lvl=%0d exp=0100 cyc=1 lvl=1", flags(), bus.cycleLevel, bus.levelIndex);
            end
            if (k == 10) begin
                checks++;
                if (bus.oneSecPulse !== 1'b1) begin
                    failures++; $display("FAIL result_pulse got=%b exp=1", bus.oneSecPulse);
                end
            end
        end
    endtask

    task automatic test_game_won();
        step(1);
        pulse_stage_end(1'b0, 1'b0);
        checks++;
        if (state_dbg !== GAME_WON || flags() !== 4'b0011) begin
            failures++; $display("FAIL game_won got=%s/%b exp=GAME_WON/0011", state_dbg.name(), flags());
        end
        step(40);
        checks++;
        if (state_dbg !== GAME_WON || flags() !== 4'b0011) begin
            failures++; $display("FAIL game_won_wait got=%s/%b exp=GAME_WON/0011", state_dbg.name(), flags());
        end
        press_start();
        checks++;
        if (flags() !== 4'b1000 || bus.levelIndex !== 2'd0) begin
            failures++; $display("FAIL won_to_title got=%b lvl=%0d exp=1000 lvl=0", flags(), bus.levelIndex);
        end
    endtask

    task automatic test_ignored_inputs();
        step(1);
        pulse_stage_end(1'b1, 1'b1);
        checks++;
        if (state_dbg !== TITLE || flags() !== 4'b1000) begin
            failures++; $display("FAIL ended_in_title got=%s/%b exp=TITLE/1000", state_dbg.name(), flags());
        end
        press_start();
        bus.stageFailed    = 1'b1;
        bus.lastLevelEnded = 1'b1;
        step(3);
        bus.stageFailed    = 1'b0;
        bus.lastLevelEnded = 1'b0;
        checks++;
        if (state_dbg !== PLAY || flags() !== 4'b0100) begin
            failures++; $display("FAIL verdict_no_strobe got=%s/%b exp=PLAY/0100", state_dbg.name(), flags());
        end
    endtask

    task automatic test_fail_simultaneous();
        bus.stageEnded  = 1'b1;
        bus.stageFailed = 1'b1;
        bus.startKey    = 1'b1;
        step(1);
        bus.stageEnded  = 1'b0;
        bus.stageFailed = 1'b0;
        checks++;
        if (state_dbg !== RESULT_FAIL || flags() !== 4'b0010) begin
            failures++; $display("FAIL ended_beats_start got=%s/%b exp=RESULT_FAIL/0010", state_dbg.name(), flags());
        end
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++;
            if (k < 20 && flags() !== 4'b0010) begin
                failures++; $display("FAIL fail_hold k=%0d got=%b exp=0010", k, flags());
            end else if (k == 20 && flags() !== 4'b1000) begin
                failures++; $display("FAIL fail_timeout got=%b exp=1000", flags());
            end
        end
        bus.startKey = 1'b0;
    endtask

    task automatic test_last_level_flag();
        press_start();
        step(2);
        pulse_stage_end(1'b0, 1'b1);
        checks++;
        if (state_dbg !== GAME_WON || bus.levelIndex !== 2'd0) begin
            failures++; $display("FAIL last_flag_won got=%s lvl=%0d exp=GAME_WON lvl=0", state_dbg.name(), bus.levelIndex);
        end
        press_start();
    endtask

    task automatic test_back_to_back();
        press_start();
        pulse_stage_end(1'b0, 1'b0);
        step(3);
        checks++;
        if (bus.levelEnable !== 1'b0) begin
            failures++; $display("FAIL reenable_gap got=%b exp=0", bus.levelEnable);
        end
        press_start();
        checks++;
        if (flags() !== 4'b0100 || bus.cycleLevel !== 1'b1 || bus.levelIndex !== 2'd1) begin
            failures++; $display("FAIL early_start_next got=%b cyc=%b lvl=%0d exp=0100 cyc=1 lvl=1", flags(), bus.cycleLevel, bus.levelIndex);
        end
        pulse_stage_end(1'b0, 1'b0);
        checks++;
        if (state_dbg !== GAME_WON || bus.levelIndex !== 2'd1) begin
            failures++; $display("FAIL top_level_won got=%s lvl=%0d exp=GAME_WON lvl=1", state_dbg.name(), bus.levelIndex);
        end
        press_start();
    endtask

    task automatic test_reset_mid_play();
        press_start();
        step(3);
        resetN = 1'b0;
        #1;
        checks++;
        if (state_dbg !== TITLE || flags() !== 4'b1000 || bus.cycleLevel !== 1'b0 || bus.levelIndex !== 2'd0) begin
            failures++; $display("FAIL async_reset got=%s/%b cyc=%b lvl=%0d exp=TITLE/1000 cyc=0 lvl=0", state_dbg.name(), flags(), bus.cycleLevel, bus.levelIndex);
        end
        step(1);
        resetN = 1'b1;
        step(2);
        checks++;
        if (state_dbg !== TITLE || bus.cycleLevel !== 1'b0) begin
            failures++; $display("FAIL after_reset got=%s cyc=%b exp=TITLE cyc=0", state_dbg.name(), bus.cycleLevel);
        end
    endtask

`ifdef PAUSE_EN
    task automatic test_pause();
        press_start();
        step(4);
        bus.pauseKey = 1'b1;
        step(1);
        checks++;
        if (bus.paused !== 1'b1) begin
            failures++; $display("FAIL pause_set got=%b exp=1", bus.paused);
        end
        for (int j = 1; j <= 50; j++) begin
            step(1);
            checks++;
            if (bus.oneSecPulse !== 1'b0 || bus.levelEnable !== 1'b1) begin
                failures++; $display("FAIL paused_hold j=%0d pulse=%b en=%b exp pulse=0 en=1", j, bus.oneSecPulse, bus.levelEnable);
            end
        end
        bus.pauseKey = 1'b0;
        step(1);
        bus.pauseKey = 1'b1;
        step(1);
        bus.pauseKey = 1'b0;
        checks++;
        if (bus.paused !== 1'b0) begin
            failures++; $display("FAIL pause_clear got=%b exp=0", bus.paused);
        end
        for (int j = 1; j <= 5; j++) begin
            step(1);
            checks++;
            if (bus.oneSecPulse !== (j == 5)) begin
                failures++; $display("FAIL resume_pulse j=%0d got=%b exp=%b", j, bus.oneSecPulse, (j == 5));
            end
        end
        pulse_stage_end(1'b1, 1'b0);
        checks++;
        if (bus.paused !== 1'b0 || state_dbg !== RESULT_FAIL) begin
            failures++; $display("FAIL pause_leave got=%b/%s exp=0/RESULT_FAIL", bus.paused, state_dbg.name());
        end
        press_start();
    endtask
`endif

    initial begin
        bus.startKey       = 1'b0;
        bus.stageEnded     = 1'b0;
        bus.stageFailed    = 1'b0;
        bus.lastLevelEnded = 1'b0;
`ifdef PAUSE_EN
        bus.pauseKey       = 1'b0;
`endif
        test_reset();
        test_start_and_pulses();
        test_result_timeout();
        test_game_won();
        test_ignored_inputs();
        test_fail_simultaneous();
        test_last_level_flag();
        test_back_to_back();
        test_reset_mid_play();
`ifdef PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
